// File: rtl/alu_control_seq_if.sv
// Handshake bundle between the main control unit (master) and alu_control_seq (slave).
// The source drives the request; the decoder returns the operation code and busy/ready status.
interface alu_control_seq_if #(
    parameter int CTRL_W = 4
);

    logic              valid_in;
    logic [1:0]        alu_op;
    logic [5:0]        funct;
    logic              ready;
    logic [CTRL_W-1:0] saida;
    logic              valid_out;
    logic              erro;
    logic              busy;
    logic              hilo_we;

    modport master (
        output valid_in,
        output alu_op,
        output funct,
        input  ready,
        input  saida,
        input  valid_out,
        input  erro,
        input  busy,
        input  hilo_we
    );

    modport slave (
        input  valid_in,
        input  alu_op,
        input  funct,
        output ready,
        output saida,
        output valid_out,
        output erro,
        output busy,
        output hilo_we
    );

endinterface

// File: rtl/alu_control_seq.sv
// Registered ALU control decoder with a busy/ready sequencer for multi-cycle MULT/DIV.
// Define ALU_CTRL_MULDIV_EN to build the mult/div decode and the MULDIV sequencer.
module alu_control_seq #(
    parameter int CTRL_W      = 4,
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input logic              clock,
    input logic              reset,
    alu_control_seq_if.slave bus
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;
`ifdef ALU_CTRL_MULDIV_EN
    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
`endif

    logic [3:0]        opCode;
    logic              unsupported;
    logic              accept;
    logic [CTRL_W-1:0] saida_q, saida_d;
    logic              validOut_q;
    logic              erro_q;
`ifdef ALU_CTRL_MULDIV_EN
    logic              isMult;
    logic              isDiv;
`endif

    // Presence of this block in the hierarchy marks an illegal parameter set.
    if (CTRL_W < 4 || MULT_CYCLES < 1 || DIV_CYCLES < 1) begin : g_illegalParams
    end

    always_comb begin
        opCode      = OP_ADD;
        unsupported = 1'b0;
`ifdef ALU_CTRL_MULDIV_EN
        isMult      = 1'b0;
        isDiv       = 1'b0;
`endif
        case (bus.alu_op)
            2'b00: opCode = OP_ADD;
            2'b01: opCode = OP_SUB;
            2'b10: begin
                case (bus.funct)
                    6'b100000, 6'b100001: opCode = OP_ADD;
                    6'b100010, 6'b100011: opCode = OP_SUB;
                    6'b100100:            opCode = OP_AND;
                    6'b100101:            opCode = OP_OR;
                    6'b100111:            opCode = OP_NOR;
                    6'b101010:            opCode = OP_SLT;
`ifdef ALU_CTRL_MULDIV_EN
                    6'b011000: begin opCode = OP_MULT;  isMult = 1'b1; end
                    6'b011001: begin opCode = OP_MULTU; isMult = 1'b1; end
                    6'b011010: begin opCode = OP_DIV;   isDiv  = 1'b1; end
                    6'b011011: begin opCode = OP_DIVU;  isDiv  = 1'b1; end
`endif
                    default: begin
                        opCode      = OP_ADD;
                        unsupported = 1'b1;
                    end
                endcase
            end
            default: begin
                opCode      = OP_ADD;
                unsupported = 1'b1;
            end
        endcase
    end

    assign accept  = bus.valid_in && bus.ready;
    assign saida_d = accept ? CTRL_W'(opCode) : saida_q;

    // Result registers: saida holds between acceptances, valid/erro are single-cycle pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            saida_q    <= '0;
            validOut_q <= 1'b0;
            erro_q     <= 1'b0;
        end else begin
            saida_q    <= saida_d;
            validOut_q <= accept;
            erro_q     <= accept && unsupported;
        end
    end

    assign bus.saida     = saida_q;
    assign bus.valid_out = validOut_q;
    assign bus.erro      = erro_q;

`ifdef ALU_CTRL_MULDIV_EN
    typedef enum logic {
        IDLE   = 1'b0,
        MULDIV = 1'b1
    } state_e;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // The counter holds the busy cycles still to come after the current one.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (accept && isMult) begin
                    state_d = MULDIV;
                    count_d = CNT_W'(MULT_CYCLES - 1);
                end else if (accept && isDiv) begin
                    state_d = MULDIV;
                    count_d = CNT_W'(DIV_CYCLES - 1);
                end
            end
            MULDIV: begin
                if (count_q == '0) begin
                    state_d = IDLE;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    assign bus.ready   = (state_q == IDLE);
    assign bus.busy    = (state_q == MULDIV);
    assign bus.hilo_we = (state_q == MULDIV) && (count_q == '0);
`else
    assign bus.ready   = 1'b1;
    assign bus.busy    = 1'b0;
    assign bus.hilo_we = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench for alu_control_seq: directed scenarios plus random traffic against a
// remaining-busy-cycles reference model. Follows ALU_CTRL_MULDIV_EN like the design.
module tb_alu_control_seq;

    localparam int CTRL_W      = 4;
    localparam int MULT_CYCLES = 4;
    localparam int DIV_CYCLES  = 32;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [CTRL_W-1:0] expSaida;
    logic              expValid;
    logic              expErro;
    int                busyLeft;

    alu_control_seq_if #(.CTRL_W(CTRL_W)) bus ();

    alu_control_seq #(
        .CTRL_W     (CTRL_W),
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Operation code as an integer, or -1 when the encoding is unsupported.
    function automatic int refCode(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'd0) return 2;
        if (op == 2'd1) return 6;
        if (op == 2'd3) return -1;
        case (int'(f))
            32, 33: return 2;
            34, 35: return 6;
            36:     return 0;
            37:     return 1;
            39:     return 12;
            42:     return 7;
`ifdef ALU_CTRL_MULDIV_EN
            24:     return 8;
            25:     return 9;
            26:     return 10;
            27:     return 11;
`endif
            default: return -1;
        endcase
    endfunction

    function automatic int refCycles(input int code);
        if (code == 8 || code == 9)   return MULT_CYCLES;
        if (code == 10 || code == 11) return DIV_CYCLES;
        return 0;
    endfunction

    task automatic modelReset();
        expSaida = '0;
        expValid = 1'b0;
        expErro  = 1'b0;
        busyLeft = 0;
    endtask

    task automatic modelEdge(input logic v, input logic [1:0] op, input logic [5:0] f);
        int code;
        if (busyLeft > 0) begin
            busyLeft--;
            expValid = 1'b0;
            expErro  = 1'b0;
        end else if (v) begin
            code     = refCode(op, f);
            expValid = 1'b1;
            if (code < 0) begin
                expErro  = 1'b1;
                expSaida = CTRL_W'(2);
            end else begin
                expErro  = 1'b0;
                expSaida = CTRL_W'(code);
                busyLeft = refCycles(code);
            end
        end else begin
            expValid = 1'b0;
            expErro  = 1'b0;
        end
    endtask

    task automatic checkAll(input string where);
        checkOutput({where, ".saida"},     32'(bus.saida),     32'(expSaida));
        checkOutput({where, ".valid_out"}, 32'(bus.valid_out), 32'(expValid));
        checkOutput({where, ".erro"},      32'(bus.erro),      32'(expErro));
        checkOutput({where, ".busy"},      32'(bus.busy),      32'(busyLeft > 0));
        checkOutput({where, ".hilo_we"},   32'(bus.hilo_we),   32'(busyLeft == 1));
        checkOutput({where, ".ready"},     32'(bus.ready),     32'(busyLeft == 0));
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [5:0] f, input string where);
        @(negedge clock);
        bus.valid_in = v;
        bus.alu_op   = op;
        bus.funct    = f;
        @(posedge clock);
        modelEdge(v, op, f);
        #1;
        checkAll(where);
    endtask

    initial begin
        logic [1:0] sweepOp [8];
        logic [5:0] sweepFn [8];
        logic [5:0] pool [16];

        reset        = 1'b0;
        bus.valid_in = 1'b0;
        bus.alu_op   = 2'b00;
        bus.funct    = 6'b000000;

        // Asynchronous reset before the first rising edge.
        #2 reset = 1'b1;
        #1;
        modelReset();
        checkAll("reset");
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        sweepOp = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
        sweepFn = '{6'b000000, 6'b111111, 6'b100100, 6'b100101, 6'b100111, 6'b101010, 6'b100001, 6'b100011};
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, sweepOp[i], sweepFn[i], "sweep");
        applyStimulus(1'b0, 2'b00, 6'b000000, "idle");

        applyStimulus(1'b1, 2'b11, 6'b100000, "unsupOp11");
        applyStimulus(1'b1, 2'b10, 6'b000000, "unsupFunct0");
        applyStimulus(1'b0, 2'b00, 6'b000000, "idle");

`ifdef ALU_CTRL_MULDIV_EN
        begin
            int busyCount;
            int hiloCount;
            int gotAt;
            applyStimulus(1'b1, 2'b10, 6'b011010, "div");
            busyCount = int'(bus.busy);
            hiloCount = int'(bus.hilo_we);
            gotAt     = -1;
            for (int w = 1; w <= 40 && gotAt < 0; w++) begin
                applyStimulus(1'b1, 2'b00, 6'b000000, "divHold");
                busyCount += int'(bus.busy);
                hiloCount += int'(bus.hilo_we);
                if (bus.valid_out === 1'b1) gotAt = w;
            end
            checkOutput("divBusyCycles", 32'(busyCount), 32'(DIV_CYCLES));
            checkOutput("divHiloPulses", 32'(hiloCount), 32'd1);
            checkOutput("divNextAcceptEdge", 32'(gotAt), 32'(DIV_CYCLES + 1));
        end
        applyStimulus(1'b0, 2'b00, 6'b000000, "idle");

        applyStimulus(1'b1, 2'b10, 6'b011000, "mult");
        applyStimulus(1'b0, 2'b00, 6'b000000, "multBusy2");
        #2 reset = 1'b1;
        #1;
        modelReset();
        checkAll("midReset");
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 2'b00, 6'b000000, "afterReset");

        applyStimulus(1'b1, 2'b10, 6'b011001, "multu");
        for (int i = 0; i < MULT_CYCLES + 1; i++) applyStimulus(1'b1, 2'b10, 6'b101010, "multuHold");
        applyStimulus(1'b1, 2'b10, 6'b011011, "divu");
        for (int i = 0; i < DIV_CYCLES; i++) applyStimulus(1'b0, 2'b00, 6'b000000, "divuWait");
`else
        applyStimulus(1'b1, 2'b10, 6'b011000, "multDisabled");
        applyStimulus(1'b1, 2'b10, 6'b011010, "divDisabled");
        applyStimulus(1'b0, 2'b00, 6'b000000, "idle");
`endif

        pool = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
                 6'b100111, 6'b101010, 6'b011000, 6'b011001, 6'b011010, 6'b011011,
                 6'b100110, 6'b101011, 6'b000000, 6'b111111};
        for (int i = 0; i < 400; i++) begin
            logic       v;
            logic [1:0] op;
            logic [5:0] f;
            v  = ($urandom_range(0, 3) != 0);
            op = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'($urandom_range(0, 3));
            f  = ($urandom_range(0, 3) != 0) ? pool[$urandom_range(0, 15)] : 6'($urandom);
            applyStimulus(v, op, f, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_control_seq.md
# alu_control_seq

Registered, parametrised ALU control decoder for the processor datapath. It sits between the main control unit and the ALU. It translates ALUOp/funct into an ALU operation code one cycle after acceptance. It also sequences multi-cycle MULT/DIV operations with a busy/ready handshake, so the pipeline stalls until HI/LO is written. Unsupported encodings raise a flag instead of being silently ignored.

## Interface
- CTRL_W, 4, width of `saida`; minimum 4; operation codes are zero-extended.
- MULT_CYCLES, 4, busy duration of MULT/MULTU in cycles; minimum 1.
- DIV_CYCLES, 32, busy duration of DIV/DIVU in cycles; minimum 1.

- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- valid_in  in  1  ALUOp/funct valid this cycle.
- alu_op  in  2  ALUOp from the main control unit.
- funct  in  6  R-type funct field.
- ready  out  1  block can accept; equals !busy.
- saida  out  CTRL_W  registered ALU operation code.
- valid_out  out  1  one-cycle pulse when `saida` is updated.
- erro  out  1  one-cycle pulse, coincident with valid_out, for an unsupported encoding.
- busy  out  1  multi-cycle operation in progress.
- hilo_we  out  1  one-cycle pulse in the final busy cycle.

## Operation
- Acceptance happens at a rising edge when valid_in && ready. Inputs are ignored at any other time.
- Operation codes:
  - AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
  - MULT 1000, MULTU 1001, DIV 1010, DIVU 1011.
- ALUOp decode:
  - 00 gives ADD.
  - 01 gives SUB.
  - 10 decodes funct.
  - 11 is unsupported.
- Funct decode (ALUOp=10):
  - 100000/100001 give ADD; 100010/100011 give SUB.
  - 100100 gives AND; 100101 gives OR; 100111 gives NOR; 101010 gives SLT.
  - 011000 gives MULT; 011001 gives MULTU; 011010 gives DIV; 011011 gives DIVU.
- Any other encoding is unsupported: `saida`=ADD, erro=1, valid_out=1, no busy.
- FSM states:
  - IDLE: ready=1. Accepting a single-cycle op stays in IDLE. Accepting a MULT* op loads the counter with MULT_CYCLES-1 and goes to MULDIV. Accepting a DIV* op loads DIV_CYCLES-1 and goes to MULDIV.
  - MULDIV: busy=1, ready=0. The counter decrements each cycle. hilo_we=(count==0). Count 0 returns to IDLE on the next edge.
- Counter width is $clog2(max(MULT_CYCLES,DIV_CYCLES))+1. No wrap-around: the FSM leaves MULDIV at count 0.
- `saida` holds its last value between acceptances, including throughout MULDIV.

## Timing
- Reset values: saida=0, valid_out=0, erro=0, busy=0, hilo_we=0, ready=1, FSM=IDLE, counter=0.
- Latency: acceptance at edge k produces saida, valid_out and erro in cycle k+1.
- For MULT/DIV with N cycles:
  - busy is high in cycles k+1..k+N.
  - hilo_we is high in cycle k+N only.
  - The earliest next acceptance is edge k+N+1.
- N=1: busy and hilo_we are both high only in cycle k+1.
- valid_in held high while busy is not accepted. No queuing; the source must hold its request.
- Back-to-back single-cycle ops are accepted every cycle, and valid_out stays high continuously.
- Reset asserted mid-MULDIV aborts immediately and asynchronously: busy=0, no hilo_we pulse, `saida`=0.
- All outputs are registered. `ready` is a direct decode of the FSM register.

## Configuration
- ALU_CTRL_MULDIV_EN defined: MULT/MULTU/DIV/DIVU decode and MULDIV sequencing are present, as described above.
- ALU_CTRL_MULDIV_EN undefined:
  - The four mult/div funct codes are unsupported (erro=1, saida=ADD).
  - The FSM and counter are removed; busy and hilo_we are tied to 0 and ready is tied to 1.
  - The MULT_CYCLES/DIV_CYCLES parameters are ignored.

## Test plan
- Reset: assert reset with no clock edge -> all outputs 0 and ready=1 immediately.
- Decode sweep: ALUOp=00 -> saida 0010; 01 -> 0110; 10 with funct 100100/100101/100111/101010 -> 0000/0001/1100/0111. Each result has valid_out=1 one cycle after acceptance, with back-to-back input every cycle.
- Unsupported: ALUOp=11, then ALUOp=10 with funct=000000 -> erro=1, valid_out=1, saida=0010, busy=0.
- DIV with DIV_CYCLES=32 accepted at edge k:
  - busy is high in cycles k+1..k+32 and hilo_we pulses only at k+32.
  - An ADD held on valid_in is accepted at edge k+33, and its saida=0010 appears in cycle k+34.
- Mid-operation reset: MULT accepted, reset asserted in the 2nd busy cycle -> busy=0 at once and hilo_we never pulses. With the macro undefined, funct 011000 -> erro=1 and busy stays 0.
